// File: rtl/dp_sink_pkg.sv
// dp_sink_pkg: shared AUX command/reply codes, FSM states and DPCD addresses
package dp_sink_pkg;
  localparam logic [3:0] CMD_NATIVE_WR = 4'b1000;
  localparam logic [3:0] CMD_NATIVE_RD = 4'b1001;
  localparam logic [1:0] ACK = 2'b00;
  localparam logic [1:0] NACK = 2'b01;
  localparam logic [1:0] DEFER = 2'b10;
  typedef enum logic [1:0] {IDLE, WR_COLLECT, REPLY_ACK, RD_DATA} state_t;
  localparam logic [19:0] ADDR_DPCD_REV = 20'h00000;
  localparam logic [19:0] ADDR_MAX_LINK_RATE = 20'h00001;
  localparam logic [19:0] ADDR_MAX_LANE_COUNT = 20'h00002;
  localparam logic [19:0] ADDR_TRAIN_RD_INTERVAL = 20'h0000E;
  localparam logic [19:0] ADDR_LINK_BW_SET = 20'h00100;
  localparam logic [19:0] ADDR_LANE_COUNT_SET = 20'h00101;
  localparam logic [19:0] ADDR_TRAINING_PATTERN = 20'h00102;
  localparam logic [19:0] ADDR_TRAIN_LANE0 = 20'h00103;
  localparam logic [19:0] ADDR_TRAIN_LANE1 = 20'h00104;
  localparam logic [19:0] ADDR_TRAIN_LANE2 = 20'h00105;
  localparam logic [19:0] ADDR_TRAIN_LANE3 = 20'h00106;
  localparam logic [19:0] ADDR_LANE01_STATUS = 20'h00202;
  localparam logic [19:0] ADDR_LANE23_STATUS = 20'h00203;
  localparam logic [19:0] ADDR_LANE_ALIGN = 20'h00204;
  localparam logic [19:0] ADDR_SINK_STATUS = 20'h00205;
  localparam logic [19:0] ADDR_ADJUST_REQ01 = 20'h00206;
  localparam logic [19:0] ADDR_ADJUST_REQ23 = 20'h00207;
endpackage

// File: rtl/dp_sink_aux_responder_dpcd_regs.sv
// dp_sink_dpcd_regs: compact DPCD map with read mux by address and byte write port
module dp_sink_dpcd_regs
  import dp_sink_pkg::*;
#(
  parameter logic [7:0] DPCD_REV = 8'h12,
  parameter logic [7:0] MAX_LINK_RATE = 8'h1E,
  parameter logic [7:0] MAX_LANE_COUNT = 8'h84,
  parameter logic [7:0] TRAIN_RD_INTERVAL = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [19:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [19:0] rd_addr,
  output logic [7:0]  rd_data,
  input  logic [15:0] lane_status,
  input  logic [7:0]  lane_align,
  input  logic [15:0] adjust_req,
  output logic [7:0]  link_bw_set,
  output logic [4:0]  lane_count_set,
  output logic [1:0]  training_pattern,
  output logic [31:0] train_lane_set
);
  logic [7:0] cfg [7];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < 7; i++) cfg[i] <= 8'h00;
    else
      for (int i = 0; i < 7; i++)
        if (wr_en && wr_addr == ADDR_LINK_BW_SET + 20'(i)) cfg[i] <= wr_data;
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_DPCD_REV:          rd_data = DPCD_REV;
      ADDR_MAX_LINK_RATE:     rd_data = MAX_LINK_RATE;
      ADDR_MAX_LANE_COUNT:    rd_data = MAX_LANE_COUNT;
      ADDR_TRAIN_RD_INTERVAL: rd_data = TRAIN_RD_INTERVAL;
      ADDR_LINK_BW_SET:       rd_data = cfg[0];
      ADDR_LANE_COUNT_SET:    rd_data = cfg[1];
      ADDR_TRAINING_PATTERN:  rd_data = cfg[2];
      ADDR_TRAIN_LANE0:       rd_data = cfg[3];
      ADDR_TRAIN_LANE1:       rd_data = cfg[4];
      ADDR_TRAIN_LANE2:       rd_data = cfg[5];
      ADDR_TRAIN_LANE3:       rd_data = cfg[6];
      ADDR_LANE01_STATUS:     rd_data = lane_status[7:0];
      ADDR_LANE23_STATUS:     rd_data = lane_status[15:8];
      ADDR_LANE_ALIGN:        rd_data = lane_align;
      ADDR_SINK_STATUS:       rd_data = 8'h00;
      ADDR_ADJUST_REQ01:      rd_data = adjust_req[7:0];
      ADDR_ADJUST_REQ23:      rd_data = adjust_req[15:8];
      default:                rd_data = 8'h00;
    endcase
  end
  assign link_bw_set = cfg[0];
  assign lane_count_set = cfg[1][4:0];
  assign training_pattern = cfg[2][1:0];
  assign train_lane_set = {cfg[6], cfg[5], cfg[4], cfg[3]};
endmodule

// File: rtl/dp_sink_aux_responder.sv
// dp_sink_aux_responder: sink-side native AUX responder with DPCD register map
module dp_sink_aux_responder
  import dp_sink_pkg::*;
#(
  parameter logic [7:0] DPCD_REV = 8'h12,
  parameter logic [7:0] MAX_LINK_RATE = 8'h1E,
  parameter logic [7:0] MAX_LANE_COUNT = 8'h84,
  parameter logic [7:0] TRAIN_RD_INTERVAL = 8'h00,
  parameter int MAX_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_vld,
  input  logic [3:0]  req_cmd,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [7:0]  req_data,
  input  logic        req_data_vld,
  input  logic        defer_req,
  input  logic [15:0] lane_status,
  input  logic [7:0]  lane_align,
  input  logic [15:0] adjust_req,
  input  logic        rpy_ready,
  output logic        rpy_ack_vld,
  output logic [1:0]  rpy_ack,
  output logic [7:0]  rpy_data,
  output logic        rpy_data_vld,
  output logic        busy,
  output logic [7:0]  link_bw_set,
  output logic [4:0]  lane_count_set,
  output logic [1:0]  training_pattern,
  output logic [31:0] train_lane_set
);
  localparam logic [8:0] MAX_N = 9'(MAX_BYTES);
  state_t state;
  logic rd;
  logic [19:0] addr;
  logic [8:0] cnt;
  logic [1:0] cls;
  logic [8:0] req_n;
  logic [1:0] req_cls;
  logic [7:0] rd_data;
  logic wr_en;
  assign req_n = {1'b0, req_len} + 9'd1;
  assign req_cls = defer_req ? DEFER :
                   (req_cmd != CMD_NATIVE_WR && req_cmd != CMD_NATIVE_RD) || req_n > MAX_N ? NACK : ACK;
  assign wr_en = state == WR_COLLECT && req_data_vld && cls == ACK;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rd <= 1'b0;
      addr <= '0;
      cnt <= '0;
      cls <= ACK;
    end else
      case (state)
        IDLE: if (req_vld) begin
          rd <= req_cmd[0];
          addr <= req_addr;
          cnt <= req_n;
          cls <= req_cls;
          state <= req_cmd[0] ? REPLY_ACK : WR_COLLECT;
        end
        WR_COLLECT: if (req_data_vld) begin
          addr <= addr + 20'd1;
          cnt <= cnt - 9'd1;
          if (cnt == 9'd1) state <= REPLY_ACK;
        end
        REPLY_ACK: if (rpy_ready) state <= rd && cls == ACK ? RD_DATA : IDLE;
        RD_DATA: if (rpy_ready) begin
          addr <= addr + 20'd1;
          cnt <= cnt - 9'd1;
          if (cnt == 9'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  // reply beats decode straight from the state register so reset clears them at once
  assign rpy_ack_vld = state == REPLY_ACK;
  assign rpy_ack = rpy_ack_vld ? cls : 2'b00;
  assign rpy_data_vld = state == RD_DATA;
  assign rpy_data = rpy_data_vld ? rd_data : 8'h00;
  assign busy = state != IDLE;
  dp_sink_dpcd_regs #(
    .DPCD_REV(DPCD_REV),
    .MAX_LINK_RATE(MAX_LINK_RATE),
    .MAX_LANE_COUNT(MAX_LANE_COUNT),
    .TRAIN_RD_INTERVAL(TRAIN_RD_INTERVAL)
  ) u_regs (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(addr),
    .wr_data(req_data),
    .rd_addr(addr),
    .rd_data(rd_data),
    .lane_status(lane_status),
    .lane_align(lane_align),
    .adjust_req(adjust_req),
    .link_bw_set(link_bw_set),
    .lane_count_set(lane_count_set),
    .training_pattern(training_pattern),
    .train_lane_set(train_lane_set)
  );
endmodule

// File: doc/dp_sink_aux_responder.md
Name: dp_sink_aux_responder

Overview:
Sink-side native AUX responder. It answers the AUX request transactions that the source transport layer issues on behalf of the SPM and LPM. It holds a compact DPCD register map: capability, link-configuration and status registers. It returns ACK/NACK/DEFER replies plus read data over a valid/ready reply stream. It is used as the sink model in source-side environments and as the basis of the sink AUX datapath.

Parameters:
DPCD_REV, 8'h12, value returned at DPCD 0x00000
MAX_LINK_RATE, 8'h1E, value returned at 0x00001
MAX_LANE_COUNT, 8'h84, value returned at 0x00002 (4 lanes, enhanced framing)
TRAIN_RD_INTERVAL, 8'h00, value returned at 0x0000E
MAX_BYTES, 16, largest legal request length in bytes

Ports:
clk  in  1  block clock
reset  in  1  asynchronous, active-high reset
req_vld  in  1  request header strobe (one cycle)
req_cmd  in  4  AUX command: 4'b1000 native write, 4'b1001 native read, 0xxx I2C
req_addr  in  20  start DPCD address
req_len  in  8  AUX LEN field (number of bytes minus 1)
req_data  in  8  write data byte
req_data_vld  in  1  write byte strobe
defer_req  in  1  forces DEFER for a request accepted in this cycle
lane_status  in  16  live contents of 0x00202–0x00203
lane_align  in  8  live contents of 0x00204
adjust_req  in  16  live contents of 0x00206–0x00207
rpy_ready  in  1  downstream accepts the reply beat
rpy_ack_vld  out  1  reply command beat valid
rpy_ack  out  2  2'b00 ACK, 2'b01 NACK, 2'b10 DEFER
rpy_data  out  8  reply data byte
rpy_data_vld  out  1  reply data beat valid
busy  out  1  high whenever not IDLE
link_bw_set  out  8  DPCD 0x00100
lane_count_set  out  5  DPCD 0x00101[4:0]
training_pattern  out  2  DPCD 0x00102[1:0]
train_lane_set  out  32  DPCD 0x00103–0x00106; lane 0 occupies bits [7:0]

Behaviour:
Reset (async, active-high):
- State goes to IDLE.
- All outputs and configuration registers go to 0.
- Reset asserted mid-transaction aborts it with no reply.

FSM states: IDLE, WR_COLLECT, REPLY_ACK, RD_DATA.

IDLE:
- req_vld latches cmd, addr, len and byte count N = req_len + 1, then classifies the request:
  - DEFER if defer_req = 1.
  - Otherwise NACK if req_cmd[3] = 0 (I2C), req_cmd is not 1000/1001, or N > MAX_BYTES.
  - Otherwise ACK.
- Write request (req_cmd[0] = 0, including NACK/DEFER writes) goes to WR_COLLECT.
- Any other request goes to REPLY_ACK.

WR_COLLECT:
- Consumes N req_data_vld bytes.
- Bytes are committed only when the classification is ACK. Each byte commits in the cycle it arrives, to the current address; the address then increments.
- After the Nth byte, goes to REPLY_ACK on the next cycle.

REPLY_ACK:
- Drives rpy_ack_vld = 1 with the classification; this beat carries no data.
- On rpy_ready, goes to RD_DATA if the request is an ACK'd read, else to IDLE.

RD_DATA:
- Presents the byte at the current address with rpy_data_vld = 1.
- On rpy_ready, the address increments and the byte counter decrements.
- After the Nth accepted beat, returns to IDLE.
- Status bytes are sampled live when each beat is presented.

Reply stream rules:
- Valid stays asserted, with data held stable, until rpy_ready.
- rpy_ack_vld and rpy_data_vld are never high together.
- Minimum latency: req_vld in cycle t gives rpy_ack_vld in cycle t+1 (read), or the cycle after the last write byte.

Register map:
- 0x00000–0x0000F are read-only capability registers from parameters; unlisted capability bytes read 0.
- 0x00100–0x00106 are read/write.
- 0x00202–0x00207 are read-only: 0x00205 reads 0, the rest come from the input ports.
- Every other address reads 8'h00.
- Writes to read-only or unmapped addresses are dropped and the transaction is still ACKed.
- 0x00101 and 0x00102 store the full byte; only the listed bits are exported.

Boundary conditions:
- Address increments modulo 2^20, so 0xFFFFF wraps to 0x00000.
- req_vld outside IDLE is ignored.
- req_data_vld outside WR_COLLECT is ignored.
- A request with N = MAX_BYTES is legal.
- A request with N = MAX_BYTES + 1 is NACKed.
- A read with len = 0 returns exactly 1 byte.

Decomposition:
- Package dp_sink_pkg holds:
  - AUX command codes (CMD_NATIVE_WR, CMD_NATIVE_RD)
  - reply codes (ACK, NACK, DEFER)
  - the state enum
  - DPCD address constants (0x00000, 0x0000E, 0x00100–0x00106, 0x00202–0x00207)
- One sub-module is natural: dp_sink_dpcd_regs. It is the register map, with a read mux by address and a byte write port.
- The FSM and counters stay in the top-level module.

Test Plan:
1. Read 0x00000, len = 2, rpy_ready tied high -> ACK beat in cycle t+1, then data 8'h12, 8'h1E, 8'h84 in consecutive cycles, busy low after the last beat.
2. Write 0x00100, len = 1, data 8'h14, 8'h84 -> link_bw_set = 8'h14 and lane_count_set = 5'h04 after the bytes land; ACK follows; read-back returns 8'h14, 8'h84.
3. Read with req_cmd = 4'b0001 (I2C) and write with N = 17 -> NACK; no data beats; write outputs unchanged after 17 bytes drained.
4. defer_req = 1 with a write to 0x00102 -> DEFER reply; training_pattern stays 0.
5. Read 0xFFFFF, len = 1, rpy_ready toggling -> bytes 8'h00, 8'h12 (wrap to 0x00000); each beat held until ready.
6. Reset asserted during RD_DATA and during WR_COLLECT -> outputs and config registers at 0; the next request is served normally.
